// File: rtl/lza_norm_shift_if.sv
// Handshake and data bundle for the LZA normalization stage.
// The master drives the input side and accepts results; the slave is the normalizer.
interface lza_norm_shift_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int POS_WIDTH   = $clog2(DATA_WIDTH);
    localparam int SHAMT_WIDTH = POS_WIDTH + 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_sum;
    logic [POS_WIDTH-1:0]   in_pos;
    logic                   in_not_zero;

    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_norm;
    logic [SHAMT_WIDTH-1:0] out_shamt;
    logic                   out_corr;
    logic                   out_zero;
    logic                   out_err;

    modport master (
        output in_valid, in_sum, in_pos, in_not_zero, out_ready,
        input  in_ready, out_valid, out_norm, out_shamt, out_corr, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_sum, in_pos, in_not_zero, out_ready,
        output in_ready, out_valid, out_norm, out_shamt, out_corr, out_zero, out_err
    );
endinterface

// File: rtl/lza_norm_shift.sv
// Purpose: left-normalize the adder sum by the predicted LZA position plus the one-bit correction.
// Latency: 2 cycles, one item per cycle.
// Backpressure: skid-free two-stage pipe; in_ready drops only while both stages hold items.
module lza_norm_shift #(
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    lza_norm_shift_if.slave   bus
);
    localparam int POS_WIDTH   = $clog2(DATA_WIDTH);
    localparam int SHAMT_WIDTH = POS_WIDTH + 1;
    localparam int MSB         = DATA_WIDTH - 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] sh;
        logic [POS_WIDTH-1:0]  pos;
        logic                  not_zero;
        logic                  lost;
        logic                  sum_nz;
    } s1_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  norm;
        logic [SHAMT_WIDTH-1:0] shamt;
        logic                   corr;
        logic                   zero;
        logic                   err;
    } s2_t;

    logic s1_valid;
    logic s2_valid;
    s1_t  s1_q;
    s1_t  s1_d;
    s2_t  s2_q;
    s2_t  s2_d;

    logic s1_advance;
    logic in_fire;
    logic [2*DATA_WIDTH-1:0] wide;

    assign s1_advance   = ~s2_valid | bus.out_ready;
    assign bus.in_ready = ~s1_valid | s1_advance;
    assign in_fire      = bus.in_valid & bus.in_ready;

    // Shifting into a double-width word keeps the bits pushed past the MSB visible as "lost".
    assign wide = {{DATA_WIDTH{1'b0}}, bus.in_sum} << bus.in_pos;

    always_comb begin
        s1_d          = '0;
        s1_d.sh       = wide[DATA_WIDTH-1:0];
        s1_d.pos      = bus.in_pos;
        s1_d.not_zero = bus.in_not_zero;
        s1_d.lost     = |wide[2*DATA_WIDTH-1:DATA_WIDTH];
        s1_d.sum_nz   = |bus.in_sum;
    end

    always_comb begin
        s2_d = '0;
        if (!s1_q.not_zero) begin
            s2_d.zero = 1'b1;
            s2_d.err  = s1_q.sum_nz;
        end else if (!s1_q.sh[MSB]) begin
            s2_d.norm  = {s1_q.sh[MSB-1:0], 1'b0};
            s2_d.shamt = SHAMT_WIDTH'(s1_q.pos) + SHAMT_WIDTH'(1);
            s2_d.corr  = 1'b1;
            // A still-clear MSB after correction means the prediction was off by more than one.
            s2_d.err   = s1_q.lost | ~s1_q.sh[MSB-1];
        end else begin
            s2_d.norm  = s1_q.sh;
            s2_d.shamt = SHAMT_WIDTH'(s1_q.pos);
            s2_d.err   = s1_q.lost;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_q     <= s1_d;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
            if (s1_advance) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_q <= s2_d;
                end
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_norm  = s2_q.norm;
    assign bus.out_shamt = s2_q.shamt;
    assign bus.out_corr  = s2_q.corr;
    assign bus.out_zero  = s2_q.zero;
    assign bus.out_err   = s2_q.err;
endmodule

// File: doc/lza_norm_shift.md
Name: lza_norm_shift

Overview:
- Normalization stage directly downstream of the leading-one detector tree in the LZA path.
- Consumes the unnormalized sum together with the predicted leading-one position (pos, counted from the MSB) and not_zero.
- Left-shifts the sum by pos, then applies the standard one-bit LZA correction shift, and reports the total shift amount.
- Two-stage pipeline with valid/ready handshake on both sides; throughput one item per cycle.

Parameters:
- DATA_WIDTH, 8, sum/mantissa width; power of two, >= 4.
- POS_WIDTH, $clog2(DATA_WIDTH), width of the predicted position; derived, not overridden.
- SHAMT_WIDTH, POS_WIDTH+1, width of the total shift amount (max DATA_WIDTH); derived.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, upstream item valid.
- in_ready, output, 1, block can accept an item this cycle.
- in_sum, input, DATA_WIDTH, unnormalized sum.
- in_pos, input, POS_WIDTH, predicted leading-one index from the MSB (0 = MSB).
- in_not_zero, input, 1, predictor found a one.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts the result.
- out_norm, output, DATA_WIDTH, normalized value.
- out_shamt, output, SHAMT_WIDTH, total left shift applied (pos + correction).
- out_corr, output, 1, correction shift was applied.
- out_zero, output, 1, result is zero.
- out_err, output, 1, prediction inconsistent with the data.

Behaviour:
- Reset: s1_valid=0, s2_valid=0, all data registers 0. out_valid=0, out_norm=0, out_shamt=0, out_corr=0, out_zero=0, out_err=0. in_ready=1 in the first cycle after reset. Reset overrides any in-flight handshake; all in-flight items are discarded.
- Handshake:
  - Transfer on in_valid&in_ready (input side) and on out_valid&out_ready (output side).
  - in_ready = ~s1_valid | s1_advance.
  - s1_advance = ~s2_valid | out_ready.
  - in_ready is combinational from out_ready; there is no other combinational in-to-out path.
  - Data on out_* is held stable while out_valid=1 and out_ready=0.
- Stage 1 (registered on input accept):
  - sh1 = in_sum << in_pos.
  - lost = OR of in_sum bits above index DATA_WIDTH-1-in_pos, i.e. bits shifted out.
  - Capture sh1, in_pos, in_not_zero, lost, and sum_nz = |in_sum.
- Stage 2 (registered on s1_advance with s1_valid):
  - If not_zero=0: norm=0, shamt=0, corr=0, zero=1, err=sum_nz.
  - Else if sh1[MSB]=0: norm=sh1<<1, shamt=pos+1, corr=1.
  - Else: norm=sh1, shamt=pos, corr=0.
  - In both not_zero=1 cases, zero=0.
  - In both not_zero=1 cases, err = lost | (norm[MSB]==0), covering overestimated pos and errors greater than one bit.
- Latency: exactly 2 cycles from input accept to out_valid when out_ready=1 throughout.
- Stall: with out_ready=0, at most 2 items are held (one per stage). in_ready drops only while both stages are full. No item is dropped or duplicated, and ordering is preserved.
- Simultaneous accept and release when full: stage 2 loads from stage 1 and stage 1 loads from the input in the same cycle.
- shamt arithmetic is unsigned, zero-extended to SHAMT_WIDTH; pos=DATA_WIDTH-1 with correction gives shamt=DATA_WIDTH without wrap.
- An asserted err does not stall the pipeline; err is per-item, not sticky.

Test Plan:
- DATA_WIDTH=8, out_ready=1: sum=0x16, pos=3, nz=1 -> 2 cycles later norm=0xB0, shamt=3, corr=0, zero=0, err=0.
- Off-by-one correction: sum=0x0B, pos=3, nz=1 -> norm=0xB0, shamt=4, corr=1, err=0. Edge case: sum=0x01, pos=6 -> norm=0x80, shamt=7, corr=1. Edge case: sum=0x01, pos=7 -> shamt=7, corr=0.
- Zero and error: sum=0x00, nz=0 -> norm=0, zero=1, err=0. sum=0x04, nz=0 -> zero=1, err=1. sum=0x80, pos=2 -> lost=1, err=1. sum=0x02, pos=2 -> shifted=0x08 is not normalized after correction (0x10), so err=1.
- Backpressure: stream 4 items back-to-back with out_ready=0 for 4 cycles -> in_ready=0 after 2 accepts. After out_ready=1, the outputs appear in order, one per cycle, with values unchanged while stalled.
- Full-throughput: 16 random consecutive items with out_ready=1 -> in_ready stays 1, outputs are contiguous and match the reference model.
- Reset mid-operation: assert rst with both stages valid -> next cycle out_valid=0 and in_ready=1, and no stale item emerges afterwards.
